// File: rtl/treeval_pkg.sv
// Shared widths, command codes and encoder state for the treeval command interface.
package treeval_pkg;

  localparam int W_ADDR         = 10;
  localparam int MAX_DATA_WIDTH = 10;
  localparam int W_REWARD       = 10;
  localparam int W_ACTION       = 3;
  localparam int W_CMD_TYPE     = 2;
  localparam int W_CMD          = 64;

  localparam logic [W_CMD_TYPE-1:0] CMD_RUN        = 2'd0;
  localparam logic [W_CMD_TYPE-1:0] CMD_SET_NODE   = 2'd1;
  localparam logic [W_CMD_TYPE-1:0] CMD_SET_CONFIG = 2'd2;
  localparam logic [W_CMD_TYPE-1:0] CMD_ILLEGAL    = 2'd3;

  localparam logic [1:0] FIELD_PAR    = 2'd0;
  localparam logic [1:0] FIELD_ACT    = 2'd1;
  localparam logic [1:0] FIELD_REW    = 2'd2;
  localparam logic [1:0] FIELD_WEIGHT = 2'd3;

  localparam logic [1:0] CONF_NODES = 2'd0;

  typedef enum logic [1:0] {
    ENC_IDLE = 2'd0,
    ENC_WAIT = 2'd1,
    ENC_DONE = 2'd2
  } enc_state_e;

endpackage

// File: rtl/treeval_cmd_fifo.sv
// DEPTH x WIDTH synchronous FIFO; the head word is read straight from storage.
module treeval_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       din_i,
  input  logic                   pop_i,
  output logic [WIDTH-1:0]       dout_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             push_ok, pop_ok;

  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign dout_o  = mem_q[rd_ptr_q];

  // A full FIFO refuses a push even when a pop happens in the same cycle.
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/treeval_cmd_encoder.sv
// Packs host load requests into 64-bit treeval commands, streams them out and
// collects the controller result after RUN, guarded by a watchdog.
module treeval_cmd_encoder #(
  parameter int DEPTH          = 4,
  parameter int TIMEOUT        = 1023,
  parameter int W_ADDR         = treeval_pkg::W_ADDR,
  parameter int MAX_DATA_WIDTH = treeval_pkg::MAX_DATA_WIDTH,
  parameter int W_REWARD       = treeval_pkg::W_REWARD,
  parameter int W_ACTION       = treeval_pkg::W_ACTION
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic [1:0]                 req_type,
  input  logic [W_ADDR-1:0]          req_addr,
  input  logic [1:0]                 req_field,
  input  logic [MAX_DATA_WIDTH-1:0]  req_data,
  output logic                       cmd_valid,
  input  logic                       cmd_ready,
  output logic [63:0]                cmd,
  input  logic                       res_valid,
  input  logic signed [W_REWARD-1:0] res_exp,
  input  logic [W_ACTION-1:0]        res_act,
  output logic signed [W_REWARD-1:0] exp,
  output logic [W_ACTION-1:0]        act,
  output logic                       done,
  output logic                       timeout,
  output logic                       busy
);

  import treeval_pkg::*;

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] T_SAT  = TW'(TIMEOUT);

  enc_state_e                 state_q, state_d;
  logic [TW-1:0]              timer_q, timer_d;
  logic signed [W_REWARD-1:0] exp_q, exp_d;
  logic [W_ACTION-1:0]        act_q, act_d;
  logic                       timeout_q, timeout_d;

  logic                       fifo_push, fifo_pop;
  logic                       fifo_full, fifo_empty;
  logic [$clog2(DEPTH):0]     fifo_count;
  logic [63:0]                fifo_head;
  logic [63:0]                packed_word;

  function automatic logic [63:0] pack_cmd(input logic [1:0]                type_i,
                                           input logic [W_ADDR-1:0]         addr_i,
                                           input logic [1:0]                field_i,
                                           input logic [MAX_DATA_WIDTH-1:0] data_i);
    logic [63:0] w;
    w = '0;
    case (type_i)
      CMD_SET_NODE: begin
        w[63:62]                = CMD_SET_NODE;
        w[61:52]                = 10'(addr_i);
        w[51:50]                = field_i;
        w[MAX_DATA_WIDTH-1:0]   = data_i;
      end
      CMD_SET_CONFIG: begin
        w[63:62]                = CMD_SET_CONFIG;
        w[61:60]                = CONF_NODES;
        w[MAX_DATA_WIDTH-1:0]   = data_i;
      end
      default: w = '0;
    endcase
    return w;
  endfunction

  assign packed_word = pack_cmd(req_type, req_addr, req_field, req_data);

  // Illegal requests complete the handshake but never reach the FIFO.
  assign req_ready = !fifo_full;
  assign fifo_push = req_valid && req_ready && (req_type != CMD_ILLEGAL);

  assign cmd_valid = (state_q == ENC_IDLE) && !fifo_empty;
  assign fifo_pop  = cmd_valid && cmd_ready;
  assign cmd       = (fifo_count != '0) ? fifo_head : '0;

  treeval_cmd_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (64)
  ) u_fifo (
    .clk_i   (clk),
    .rst_ni  (rst),
    .push_i  (fifo_push),
    .din_i   (packed_word),
    .pop_i   (fifo_pop),
    .dout_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    exp_d     = exp_q;
    act_d     = act_q;
    timeout_d = 1'b0;
    case (state_q)
      ENC_IDLE: begin
        if (fifo_pop && (fifo_head[63:62] == CMD_RUN)) begin
          state_d = ENC_WAIT;
          timer_d = '0;
        end
      end
      ENC_WAIT: begin
        // A result arriving on the expiry cycle still counts as a result.
        if (res_valid) begin
          exp_d   = res_exp;
          act_d   = res_act;
          state_d = ENC_DONE;
        end else if (timer_q == T_LAST) begin
          timeout_d = 1'b1;
          state_d   = ENC_IDLE;
        end else if (timer_q != T_SAT) begin
          timer_d = timer_q + TW'(1);
        end
      end
      ENC_DONE: state_d = ENC_IDLE;
      default:  state_d = ENC_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ENC_IDLE;
      timer_q   <= '0;
      exp_q     <= '0;
      act_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      exp_q     <= exp_d;
      act_q     <= act_d;
      timeout_q <= timeout_d;
    end
  end

  assign exp     = exp_q;
  assign act     = act_q;
  assign done    = (state_q == ENC_DONE);
  assign timeout = timeout_q;
  assign busy    = (state_q == ENC_WAIT) || (state_q == ENC_DONE);

endmodule

// File: tb/tb_treeval_cmd_encoder.sv
// Directed bench for treeval_cmd_encoder with a queue-based scoreboard monitor.
module tb_treeval_cmd_encoder;

  logic              clk = 1'b0;
  logic              rst;
  logic              req_valid, req_ready;
  logic [1:0]        req_type;
  logic [9:0]        req_addr;
  logic [1:0]        req_field;
  logic [9:0]        req_data;
  logic              cmd_valid, cmd_ready;
  logic [63:0]       cmd;
  logic              res_valid;
  logic signed [9:0] res_exp;
  logic [2:0]        res_act;
  logic signed [9:0] exp_s;
  logic [2:0]        act_s;
  logic              done_s, timeout_s, busy_s;

  typedef struct {
    logic       to;
    logic [9:0] ex;
    logic [2:0] ac;
  } res_t;

  logic [63:0] cmd_q[$];
  res_t        res_q[$];
  int          checks = 0;
  int          errors = 0;

  treeval_cmd_encoder #(.DEPTH(4), .TIMEOUT(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_type  (req_type),
    .req_addr  (req_addr),
    .req_field (req_field),
    .req_data  (req_data),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd       (cmd),
    .res_valid (res_valid),
    .res_exp   (res_exp),
    .res_act   (res_act),
    .exp       (exp_s),
    .act       (act_s),
    .done      (done_s),
    .timeout   (timeout_s),
    .busy      (busy_s)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, got, want);
    end
  endtask

  // Scoreboard monitor: compares every issued word and every result pulse.
  always @(negedge clk) begin
    if (rst) begin
      if (cmd_valid && cmd_ready) begin
        if (cmd_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL cmd_unexpected got %h want none", cmd);
        end else begin
          chk("cmd_word", cmd, cmd_q.pop_front());
        end
      end
      if (done_s || timeout_s) begin
        if (res_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL result_unexpected got done=%0b timeout=%0b want none", done_s, timeout_s);
        end else begin
          res_t r;
          r = res_q.pop_front();
          chk("res_is_timeout", {63'd0, timeout_s}, {63'd0, r.to});
          chk("res_exp", {54'd0, exp_s}, {54'd0, r.ex});
          chk("res_act", {61'd0, act_s}, {61'd0, r.ac});
        end
      end
    end
  end

  task automatic send(input logic [1:0] t, input logic [9:0] a, input logic [1:0] f,
                      input logic [9:0] d, input logic [63:0] w);
    int n;
    req_valid = 1'b1; req_type = t; req_addr = a; req_field = f; req_data = d;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!req_ready) begin
      checks++; errors++;
      $display("FAIL req_accept got ready=0 want ready=1");
    end else if (t != 2'd3) begin
      cmd_q.push_back(w);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_busy();
    int n;
    n = 0;
    @(posedge clk); #1;
    while (!busy_s && n < 50) begin
      n++;
      @(posedge clk); #1;
    end
    chk("busy_rise", {63'd0, busy_s}, 64'd1);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (cmd_q.size() != 0 && n < 50) begin
      n++;
      @(posedge clk); #1;
    end
    chk("drain_left", 64'(cmd_q.size()), 64'd0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req_ready"}, {63'd0, req_ready}, 64'd1);
    chk({tag, "_cmd_valid"}, {63'd0, cmd_valid}, 64'd0);
    chk({tag, "_cmd"}, cmd, 64'd0);
    chk({tag, "_exp"}, {54'd0, exp_s}, 64'd0);
    chk({tag, "_act"}, {61'd0, act_s}, 64'd0);
    chk({tag, "_done"}, {63'd0, done_s}, 64'd0);
    chk({tag, "_timeout"}, {63'd0, timeout_s}, 64'd0);
    chk({tag, "_busy"}, {63'd0, busy_s}, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got no finish want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    req_valid = 0; req_type = 0; req_addr = 0; req_field = 0; req_data = 0;
    cmd_ready = 0; res_valid = 0; res_exp = 0; res_act = 0;
    #3 rst = 1'b0;
    #1 chk_reset_outputs("rst0");
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    // Packing and one-cycle latency
    cmd_ready = 1'b1;
    send(2'd1, 10'd5, 2'b10, 10'h3FF, 64'h4058_0000_0000_03FF);
    chk("lat_valid", {63'd0, cmd_valid}, 64'd1);
    chk("lat_cmd", cmd, 64'h4058_0000_0000_03FF);
    send(2'd2, 10'd0, 2'b00, 10'd7, 64'h8000_0000_0000_0007);
    wait_drain();

    // Fill with the consumer stalled, then a fifth request waits for a pop
    cmd_ready = 1'b0;
    send(2'd1, 10'h3FF, 2'b11, 10'h3FF, 64'h7FFC_0000_0000_03FF);
    send(2'd1, 10'h001, 2'b00, 10'h000, 64'h4010_0000_0000_0000);
    send(2'd2, 10'h000, 2'b00, 10'h3FF, 64'h8000_0000_0000_03FF);
    send(2'd1, 10'h200, 2'b01, 10'h155, 64'h6004_0000_0000_0155);
    chk("full_ready", {63'd0, req_ready}, 64'd0);
    chk("full_head", cmd, 64'h7FFC_0000_0000_03FF);
    fork
      send(2'd2, 10'h000, 2'b00, 10'h2AA, 64'h8000_0000_0000_02AA);
      begin
        repeat (3) @(posedge clk);
        #2;
        chk("held_ready", {63'd0, req_ready}, 64'd0);
        chk("held_head", cmd, 64'h7FFC_0000_0000_03FF);
        cmd_ready = 1'b1;
        @(posedge clk); #1;
        chk("pop_frees", {63'd0, req_ready}, 64'd1);
      end
    join
    wait_drain();

    // RUN behind two node writes, result 3 cycles after the pop
    cmd_ready = 1'b0;
    send(2'd1, 10'd1, 2'b00, 10'd2, 64'h4010_0000_0000_0002);
    send(2'd1, 10'd2, 2'b01, 10'd3, 64'h4024_0000_0000_0003);
    send(2'd0, 10'd0, 2'b00, 10'd0, 64'h0);
    cmd_ready = 1'b1;
    wait_busy();
    chk("wait_no_valid", {63'd0, cmd_valid}, 64'd0);
    repeat (2) begin @(posedge clk); #1; end
    res_valid = 1'b1; res_exp = -10'sd3; res_act = 3'd2;
    res_q.push_back('{to: 1'b0, ex: 10'h3FD, ac: 3'd2});
    @(posedge clk); #1;
    res_valid = 1'b0;
    chk("done_pulse", {63'd0, done_s}, 64'd1);
    chk("busy_in_done", {63'd0, busy_s}, 64'd1);
    @(posedge clk); #1;
    chk("done_cleared", {63'd0, done_s}, 64'd0);
    chk("busy_fall", {63'd0, busy_s}, 64'd0);
    chk("exp_hold", {54'd0, exp_s}, 64'h3FD);

    // Watchdog expiry after 8 WAIT cycles
    send(2'd0, 10'd0, 2'b00, 10'd0, 64'h0);
    wait_busy();
    res_q.push_back('{to: 1'b1, ex: 10'h3FD, ac: 3'd2});
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #1;
      chk($sformatf("to_pulse_%0d", k), {63'd0, timeout_s}, (k == 8) ? 64'd1 : 64'd0);
      chk($sformatf("to_busy_%0d", k), {63'd0, busy_s}, (k == 8) ? 64'd0 : 64'd1);
    end
    chk("to_act_kept", {61'd0, act_s}, 64'd2);

    // Result on the expiry cycle wins
    send(2'd0, 10'd0, 2'b00, 10'd0, 64'h0);
    wait_busy();
    repeat (7) begin @(posedge clk); #1; end
    res_valid = 1'b1; res_exp = 10'sd123; res_act = 3'd5;
    res_q.push_back('{to: 1'b0, ex: 10'd123, ac: 3'd5});
    @(posedge clk); #1;
    res_valid = 1'b0;
    chk("race_done", {63'd0, done_s}, 64'd1);
    chk("race_no_to", {63'd0, timeout_s}, 64'd0);
    @(posedge clk); #1;
    chk("race_no_to_late", {63'd0, timeout_s}, 64'd0);

    // Illegal request and stray result in IDLE
    send(2'd3, 10'd9, 2'b11, 10'h3FF, 64'h0);
    res_valid = 1'b1; res_exp = -10'sd1; res_act = 3'd7;
    @(posedge clk); #1;
    res_valid = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    chk("ill_no_cmd", {63'd0, cmd_valid}, 64'd0);
    chk("idle_exp", {54'd0, exp_s}, 64'd123);
    chk("idle_act", {61'd0, act_s}, 64'd5);
    chk("idle_busy", {63'd0, busy_s}, 64'd0);

    // Reset during WAIT with words queued behind it
    send(2'd0, 10'd0, 2'b00, 10'd0, 64'h0);
    wait_busy();
    send(2'd2, 10'd0, 2'b00, 10'd1, 64'h8000_0000_0000_0001);
    send(2'd2, 10'd0, 2'b00, 10'd2, 64'h8000_0000_0000_0002);
    #2 rst = 1'b0;
    cmd_q.delete();
    res_q.delete();
    #1 chk_reset_outputs("rst_mid");
    @(posedge clk); #1 rst = 1'b1;
    repeat (4) begin @(posedge clk); #1; end
    chk("post_rst_valid", {63'd0, cmd_valid}, 64'd0);
    chk("post_rst_ready", {63'd0, req_ready}, 64'd1);
    send(2'd2, 10'd0, 2'b00, 10'd9, 64'h8000_0000_0000_0009);
    wait_drain();
    repeat (3) begin @(posedge clk); #1; end
    chk("res_q_empty", 64'(res_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
